// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//   Scans a 4x4 matrix keypad. One row at a time is driven low. The active-low
//   columns are sampled near the end of each row's dwell. Whole scan frames are
//   debounced, and frames that show more than one closed contact are rejected.
//   Each debounced key event is handed to the consumer through a one-entry
//   valid/ready register.
//
//   Optional feature: define KEYPAD_AUTOREPEAT_EN to re-emit a held key after
//   REPEAT_DELAY frames, then every REPEAT_RATE frames.
//
// Ports
//   clk_clk               in   system clock
//   reset_reset           in   asynchronous reset, active-high
//   keypad_row_export     out  [3:0] row drive, active-low (one row low while scanning)
//   keypad_column_export  in   [3:0] column sense, active-low, asynchronous to clk
//   key_valid             out  key_code holds an unconsumed event
//   key_code              out  [3:0] {row[1:0], col[1:0]}
//   key_ready             in   consumer accepts when key_valid & key_ready
//   key_pressed           out  a debounced key is currently held
//   overflow              out  sticky, an event was dropped
//   overflow_clr          in   one-cycle pulse, clears overflow
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
    parameter int ROW_DWELL       = 50000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_RATE     = 100
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    output logic [3:0] keypad_row_export,
    input  logic [3:0] keypad_column_export,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       key_pressed,
    output logic       overflow,
    input  logic       overflow_clr
);

    localparam int DW = $clog2(ROW_DWELL);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_EVAL} state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_row, w_row_nxt;
    logic [DW-1:0] r_dwell;
    logic [3:0]  r_rows, w_rows_nxt;
    logic [3:0]  r_col_meta, r_col_sync;
    logic [1:0]  r_hits;               // closed contacts this frame, saturates at 2
    logic [3:0]  r_hit_code;
    logic [4:0]  r_prev_cand;          // {valid, code}; 5'b0 means no key
    logic [CW-1:0] r_cnt;
    logic [4:0]  r_stable;
    logic        r_key_valid;
    logic [3:0]  r_key_code;
    logic        r_overflow;

    logic        w_last_dwell, w_sample, w_eval;
    logic [3:0]  w_row_lows;
    logic [2:0]  w_row_ones, w_hit_total;
    logic [1:0]  w_col_idx;
    logic [4:0]  w_frame_cand;
    logic [CW-1:0] w_cnt_nxt;
    logic        w_change, w_press, w_repeat, w_load, w_accept, w_ovf_set;
    logic [3:0]  w_load_code;

    // ---------------- scan FSM ----------------
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_row_nxt    = r_row;
        w_last_dwell = (r_dwell == DW'(ROW_DWELL - 1));
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_DRIVE;
                w_row_nxt   = 2'd0;
            end
            S_DRIVE: begin
                if (w_last_dwell) begin
                    // Row 3 stays driven through EVAL. Only rows 0-2 advance here.
                    if (r_row == 2'd3) w_state_nxt = S_EVAL;
                    else               w_row_nxt   = r_row + 2'd1;
                end
            end
            S_EVAL: begin
                w_state_nxt = S_DRIVE;
                w_row_nxt   = 2'd0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_sample   = (r_state == S_DRIVE) && w_last_dwell;
        w_eval     = (r_state == S_EVAL);
        w_rows_nxt = (w_state_nxt == S_IDLE) ? 4'hF : ~(4'b0001 << w_row_nxt);
    end

    // ---------------- sampling datapath ----------------
    assign w_row_lows  = ~r_col_sync;
    assign w_row_ones  = 3'(w_row_lows[0]) + 3'(w_row_lows[1]) + 3'(w_row_lows[2]) + 3'(w_row_lows[3]);
    assign w_hit_total = {1'b0, r_hits} + w_row_ones;

    always_comb begin
        w_col_idx = 2'd0;
        case (w_row_lows)
            4'b0010: w_col_idx = 2'd1;
            4'b0100: w_col_idx = 2'd2;
            4'b1000: w_col_idx = 2'd3;
            default: w_col_idx = 2'd0;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_col_meta <= 4'hF;
            r_col_sync <= 4'hF;
            r_rows     <= 4'hF;
            r_row      <= 2'd0;
            r_dwell    <= '0;
            r_hits     <= 2'd0;
            r_hit_code <= 4'd0;
        end else begin
            r_col_meta <= keypad_column_export;
            r_col_sync <= r_col_meta;
            r_rows     <= w_rows_nxt;
            r_row      <= w_row_nxt;
            r_dwell    <= (r_state == S_DRIVE && !w_last_dwell) ? r_dwell + DW'(1) : '0;
            if (w_sample) begin
                r_hits <= (w_hit_total >= 3'd2) ? 2'd2 : w_hit_total[1:0];
                if (w_row_ones == 3'd1) r_hit_code <= {r_row, w_col_idx};
            end else if (w_eval) begin
                r_hits <= 2'd0;
            end
        end
    end

    // ---------------- frame debounce ----------------
    assign w_frame_cand = (r_hits == 2'd1) ? {1'b1, r_hit_code} : 5'd0;
    assign w_cnt_nxt    = (w_frame_cand != r_prev_cand) ? CW'(1) :
                          (r_cnt == CW'(DEBOUNCE_FRAMES)) ? r_cnt : r_cnt + CW'(1);
    assign w_change     = w_eval && (w_cnt_nxt == CW'(DEBOUNCE_FRAMES)) && (w_frame_cand != r_stable);
    assign w_press      = w_change && w_frame_cand[4];

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_prev_cand <= 5'd0;
            r_cnt       <= '0;
            r_stable    <= 5'd0;
        end else if (w_eval) begin
            r_prev_cand <= w_frame_cand;
            r_cnt       <= w_cnt_nxt;
            if (w_change) r_stable <= w_frame_cand;
        end
    end

    // ---------------- auto-repeat ----------------
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);

    logic [RW-1:0] r_rep_cnt, w_rep_inc;
    logic          r_rep_first, w_rep_hit;

    // Frames counted since the press or the last repeat. The first gap is REPEAT_DELAY, later gaps are REPEAT_RATE.
    assign w_rep_inc = r_rep_cnt + RW'(1);
    assign w_rep_hit = r_rep_first ? (w_rep_inc == RW'(REPEAT_DELAY)) : (w_rep_inc == RW'(REPEAT_RATE));
    assign w_repeat  = w_eval && !w_change && r_stable[4] && w_rep_hit;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_change) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_eval && r_stable[4]) begin
            if (w_rep_hit) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b0;
            end else begin
                r_rep_cnt   <= w_rep_inc;
            end
        end
    end
`else
    // Repeat timing has no effect without auto-repeat. It is folded into a tied-off net.
    logic w_unused_repeat;
    assign w_unused_repeat = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
    assign w_repeat        = 1'b0;
`endif

    // ---------------- output register ----------------
    assign w_load      = w_press | w_repeat;
    assign w_load_code = w_press ? w_frame_cand[3:0] : r_stable[3:0];
    assign w_accept    = r_key_valid & key_ready;
    assign w_ovf_set   = w_load && r_key_valid && !w_accept;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_load && (!r_key_valid || w_accept)) begin
                r_key_valid <= 1'b1;
                r_key_code  <= w_load_code;
            end else if (w_accept) begin
                r_key_valid <= 1'b0;
            end
            if (overflow_clr)   r_overflow <= 1'b0;
            else if (w_ovf_set) r_overflow <= 1'b1;
        end
    end

    assign keypad_row_export = r_rows;
    assign key_valid         = r_key_valid;
    assign key_code          = r_key_code;
    assign key_pressed       = r_stable[4];
    assign overflow          = r_overflow;

endmodule
